// File: rtl/instr_fetch_ctrl.sv
// Fetch-stage controller: one outstanding imem request at a time, a single-word
// instruction buffer for decode, branch-flush handling and a saturating response timeout.
module instr_fetch_ctrl #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PCF,
   input  logic        StallD,
   input  logic        FlushF,
   output logic        StallF,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic [31:0] InstrF,
   output logic        InstrValidF,
   output logic        FetchErr
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      DRAIN,
      HOLD
   } state_t;

   state_t        state_reg, state_next;
   logic [31:0]   instr_reg, instr_next;
   logic          valid_reg, valid_next;
   logic          err_reg, err_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic [CW-1:0] cnt_inc;
   logic          timeout_hit;
   logic          stall_f;
   logic          req_valid;

   // Saturating increment so a counter held at the limit never wraps back to zero.
   assign cnt_inc     = (cnt_reg == TIMEOUT_C) ? cnt_reg : cnt_reg + CW'(1);
   assign timeout_hit = (cnt_inc == TIMEOUT_C);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         instr_reg <= NOP_INSTR;
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         instr_reg <= instr_next;
         valid_reg <= valid_next;
         err_reg   <= err_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      instr_next = instr_reg;
      valid_next = valid_reg;
      err_next   = err_reg;
      cnt_next   = cnt_reg;
      stall_f    = 1'b1;
      req_valid  = 1'b0;

      case (state_reg)
         IDLE: state_next = REQ;
         REQ: begin
            req_valid = !FlushF;
            if (req_valid && imem_req_ready) begin
               state_next = WAIT;
               cnt_next   = '0;
            end
         end
         WAIT: begin
            if (imem_rsp_valid) begin
               if (FlushF) begin
                  state_next = REQ;
               end else begin
                  instr_next = imem_rsp_data;
                  valid_next = 1'b1;
                  state_next = HOLD;
               end
            end else begin
               cnt_next = cnt_inc;
               if (FlushF) begin
                  state_next = DRAIN;
               end else if (timeout_hit) begin
                  instr_next = NOP_INSTR;
                  valid_next = 1'b1;
                  err_next   = 1'b1;
                  state_next = HOLD;
               end
            end
         end
         DRAIN: begin
            // The orphaned response belongs to a squashed PC; it is consumed and dropped.
            if (imem_rsp_valid) begin
               state_next = REQ;
            end else begin
               cnt_next = cnt_inc;
               if (!FlushF && timeout_hit) begin
                  err_next   = 1'b1;
                  state_next = REQ;
               end
            end
         end
         HOLD: begin
            if (FlushF || !StallD) begin
               stall_f    = 1'b0;
               valid_next = 1'b0;
               state_next = REQ;
            end
         end
         default: state_next = IDLE;
      endcase

      if (FlushF) begin
         stall_f    = 1'b0;
         valid_next = 1'b0;
         instr_next = NOP_INSTR;
      end

      // Keep the PC register frozen while reset is held, whatever FlushF does.
      if (!reset) begin
         stall_f   = 1'b1;
         req_valid = 1'b0;
      end
   end

   assign StallF         = stall_f;
   assign imem_req_valid = req_valid;
   assign imem_req_addr  = PCF;
   assign InstrF         = instr_reg;
   assign InstrValidF    = valid_reg;
   assign FetchErr       = err_reg;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a flag-based model of the fetch contract checked
// every cycle, plus hand-computed checks pinned to the documented timing.
module tb_instr_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int          TO  = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] PCF;
   logic        StallD, FlushF;
   logic        StallF, imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready, imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic [31:0] InstrF;
   logic        InstrValidF, FetchErr;

   int n_tests = 0;
   int n_fail  = 0;
   int cycle   = 0;

   instr_fetch_ctrl #(.NOP_INSTR(NOP), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset), .PCF(PCF), .StallD(StallD), .FlushF(FlushF),
      .StallF(StallF), .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
      .imem_req_ready(imem_req_ready), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .InstrF(InstrF), .InstrValidF(InstrValidF),
      .FetchErr(FetchErr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, required %h", name, cycle, act, exp);
      end
   endtask

   // Model: started = first cycle after reset has passed; pending = a request is in
   // flight for us; orphan = an in-flight response must be dropped; mvalid = buffer full.
   bit          m_started, m_pending, m_orphan, m_valid, m_err;
   logic [31:0] m_instr;
   int          m_waited;

   always @(posedge clk or negedge reset) begin
      bit s, p, o, v, e;
      logic [31:0] w;
      int n;
      if (!reset) begin
         m_started <= 0; m_pending <= 0; m_orphan <= 0; m_valid <= 0; m_err <= 0;
         m_instr <= NOP; m_waited <= 0;
      end else begin
         s = m_started; p = m_pending; o = m_orphan; v = m_valid; e = m_err;
         w = m_instr; n = m_waited;
         if (!s) begin
            s = 1;
         end else if (o) begin
            if (imem_rsp_valid) o = 0;
            else begin
               n = (n + 1 > TO) ? TO : n + 1;
               if (!FlushF && n == TO) begin o = 0; e = 1; end
            end
         end else if (p) begin
            if (imem_rsp_valid) begin
               p = 0;
               if (!FlushF) begin v = 1; w = imem_rsp_data; end
            end else begin
               n = (n + 1 > TO) ? TO : n + 1;
               if (FlushF) begin p = 0; o = 1; end
               else if (n == TO) begin p = 0; v = 1; w = NOP; e = 1; end
            end
         end else if (v) begin
            if (FlushF || !StallD) begin
               v = 0;
               $display("[TB] cycle %0d handoff instr=%h", cycle, w);
            end
         end else if (!FlushF && imem_req_ready) begin
            p = 1; n = 0;
         end
         if (FlushF) begin v = 0; w = NOP; end
         m_started <= s; m_pending <= p; m_orphan <= o; m_valid <= v; m_err <= e;
         m_instr <= w; m_waited <= n;
      end
   end

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         chk("model_req_valid", {31'd0, imem_req_valid},
             {31'd0, m_started && !m_pending && !m_orphan && !m_valid && !FlushF});
         chk("model_stallf", {31'd0, StallF}, {31'd0, !(FlushF || (m_valid && !StallD))});
         chk("model_addr", imem_req_addr, PCF);
         chk("model_instr", InstrF, m_instr);
         chk("model_valid", {31'd0, InstrValidF}, {31'd0, m_valid});
         chk("model_err", {31'd0, FetchErr}, {31'd0, m_err});
      end
   end

   task automatic cyc(input logic rdy, input logic rsp, input logic [31:0] data,
                      input logic sd, input logic fl, input logic [31:0] pc);
      @(posedge clk); #1;
      imem_req_ready = rdy; imem_rsp_valid = rsp; imem_rsp_data = data;
      StallD = sd; FlushF = fl; PCF = pc;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 0; PCF = 0; StallD = 0; FlushF = 0;
      imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = 0;
      repeat (3) @(posedge clk);
      #1 FlushF = 1; #1;
      chk("reset_stallf_flush", {31'd0, StallF}, 32'd1);
      chk("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("reset_instr", InstrF, NOP);
      chk("reset_err", {31'd0, FetchErr}, 32'd0);
      FlushF = 0;
      @(posedge clk); #1 reset = 1;
      @(negedge clk);
      chk("idle_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("idle_stallf", {31'd0, StallF}, 32'd1);

      // Basic fetch: request at cycle 1, response at 2, handoff at 3.
      cyc(1, 0, 0, 0, 0, 32'h0);
      chk("c1_req_valid", {31'd0, imem_req_valid}, 32'd1);
      cyc(1, 1, 32'h0050_0093, 0, 0, 32'h0);
      chk("c2_valid", {31'd0, InstrValidF}, 32'd0);
      cyc(0, 0, 0, 0, 0, 32'h0);
      chk("c3_instr", InstrF, 32'h0050_0093);
      chk("c3_valid", {31'd0, InstrValidF}, 32'd1);
      chk("c3_stallf", {31'd0, StallF}, 32'd0);

      // Decode stall for four cycles in HOLD.
      cyc(1, 0, 0, 1, 0, 32'h4);
      chk("ds_req_addr", imem_req_addr, 32'h4);
      cyc(1, 1, 32'h00a0_0113, 1, 0, 32'h4);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 1, 0, 32'h4);
         chk("ds_stallf", {31'd0, StallF}, 32'd1);
         chk("ds_instr", InstrF, 32'h00a0_0113);
      end
      cyc(0, 0, 0, 0, 0, 32'h4);
      chk("ds_handoff", {31'd0, StallF}, 32'd0);

      // Flush one cycle after acceptance, stale response three cycles later.
      cyc(1, 0, 0, 0, 0, 32'h8);
      cyc(0, 0, 0, 0, 1, 32'h8);
      chk("fw_stallf", {31'd0, StallF}, 32'd0);
      cyc(0, 0, 0, 0, 0, 32'h100);
      chk("fw_drain_req", {31'd0, imem_req_valid}, 32'd0);
      chk("fw_drain_stallf", {31'd0, StallF}, 32'd1);
      cyc(0, 0, 0, 0, 0, 32'h100);
      cyc(0, 1, 32'hdead_beef, 0, 0, 32'h100);
      cyc(1, 0, 0, 0, 0, 32'h100);
      chk("fw_new_req", {31'd0, imem_req_valid}, 32'd1);
      chk("fw_new_addr", imem_req_addr, 32'h100);
      chk("fw_dropped", {31'd0, InstrValidF}, 32'd0);

      // Flush coincident with the response.
      cyc(0, 1, 32'h1234_5678, 0, 1, 32'h100);
      chk("fr_stallf", {31'd0, StallF}, 32'd0);
      cyc(0, 1, 32'hcafe_f00d, 0, 0, 32'h200);
      chk("fr_req", {31'd0, imem_req_valid}, 32'd1);
      chk("fr_instr", InstrF, NOP);
      chk("fr_valid", {31'd0, InstrValidF}, 32'd0);

      // Backpressure: ready low for five cycles, stray responses ignored.
      for (int i = 0; i < 4; i++) begin
         cyc(0, logic'(i % 2), 32'h5555_0000, 0, 0, 32'h200);
         chk("bp_req", {31'd0, imem_req_valid}, 32'd1);
         chk("bp_addr", imem_req_addr, 32'h200);
         chk("bp_stallf", {31'd0, StallF}, 32'd1);
      end
      cyc(1, 0, 0, 0, 0, 32'h200);

      // Timeout after four silent WAIT cycles.
      for (int i = 0; i < TO; i++) begin
         cyc(0, 0, 0, 0, 0, 32'h200);
         chk("to_err_early", {31'd0, FetchErr}, 32'd0);
         chk("to_valid_early", {31'd0, InstrValidF}, 32'd0);
      end
      cyc(0, 0, 0, 1, 0, 32'h200);
      chk("to_err", {31'd0, FetchErr}, 32'd1);
      chk("to_instr", InstrF, 32'h0000_0013);
      chk("to_valid", {31'd0, InstrValidF}, 32'd1);
      cyc(0, 0, 0, 0, 0, 32'h200);
      chk("to_handoff", {31'd0, StallF}, 32'd0);
      cyc(1, 0, 0, 0, 0, 32'h204);
      cyc(0, 1, 32'h0000_0533, 0, 0, 32'h204);
      cyc(0, 0, 0, 1, 1, 32'h204);
      chk("fh_stallf", {31'd0, StallF}, 32'd0);
      cyc(0, 0, 0, 0, 0, 32'h300);
      chk("fh_valid", {31'd0, InstrValidF}, 32'd0);
      chk("err_sticky", {31'd0, FetchErr}, 32'd1);

      // Irregular traffic, checked by the model only.
      for (int i = 0; i < 300; i++)
         cyc(logic'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, $urandom,
             $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0, {$urandom_range(0, 255), 2'b00});

      // Reset clears the error; then reset in WAIT ignores the late response.
      @(posedge clk); #1 reset = 0;
      @(posedge clk); #1 reset = 1; FlushF = 0; StallD = 0; imem_rsp_valid = 0;
      @(negedge clk);
      chk("rst_err_clear", {31'd0, FetchErr}, 32'd0);
      cyc(1, 0, 0, 0, 0, 32'h40);
      cyc(0, 0, 0, 0, 0, 32'h40);
      @(posedge clk); #1 reset = 0; imem_rsp_valid = 1; imem_rsp_data = 32'hbad0_0bad;
      #1;
      chk("rw_stallf", {31'd0, StallF}, 32'd1);
      chk("rw_valid", {31'd0, InstrValidF}, 32'd0);
      @(posedge clk); #1 reset = 1;
      @(negedge clk);
      chk("rw_idle_valid", {31'd0, InstrValidF}, 32'd0);
      cyc(0, 1, 32'hbad0_0bad, 0, 0, 32'h40);
      chk("rw_req", {31'd0, imem_req_valid}, 32'd1);
      chk("rw_req_valid_instr", {31'd0, InstrValidF}, 32'd0);
      cyc(1, 0, 0, 0, 0, 32'h40);
      cyc(0, 1, 32'h0010_0073, 0, 0, 32'h40);
      cyc(0, 0, 0, 0, 0, 32'h40);
      chk("rw_fetch_instr", InstrF, 32'h0010_0073);
      chk("rw_fetch_valid", {31'd0, InstrValidF}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
